ulpi_phy_model: RTL and testbench

//  Synthesizable PHY-side ULPI responder, the counterpart of ulpi_link. Owns dir/nxt.

---
 rtl/ulpi_phy_model_if.sv | 19 +
 rtl/ulpi_phy_model.sv | 158 +++++++++++++++
 tb/tb_ulpi_phy_model.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_phy_model_if.sv
// rtl/ulpi_phy_model_if.sv - ULPI bus bundle between link (master) and PHY model (slave)
interface ulpi_phy_model_if;
  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;

  modport master (
    output ulpi_data_i, ulpi_stp,
    input  ulpi_data_o, ulpi_data_oe, ulpi_dir, ulpi_nxt
  );

  modport slave (
    input  ulpi_data_i, ulpi_stp,
    output ulpi_data_o, ulpi_data_oe, ulpi_dir, ulpi_nxt
  );
endinterface

// File: rtl/ulpi_phy_model.sv
// rtl/ulpi_phy_model.sv - PHY-side ULPI responder: register access, TX packets, RX CMD injection
// Optional extended register addressing via ULPI_PHY_EXTREG_EN.
module ulpi_phy_model #(
  parameter int          REG_COUNT = 16,
  parameter logic [15:0] VENDOR_ID = 16'h0424
) (
  input  logic              clk,
  input  logic              reset,
  ulpi_phy_model_if.slave   bus,
  input  logic [7:0]        rxcmd,
  input  logic              rxcmd_valid,
  output logic              rxcmd_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  output logic              reg_wr_strobe,
  output logic [7:0]        reg_wr_addr,
  output logic [7:0]        reg_wr_data
);
  localparam int         AW      = $clog2(REG_COUNT);
  localparam logic [8:0] REG_LIM = 9'(REG_COUNT);

  typedef enum logic [1:0] {C_IDLE = 2'b00, C_TXPKT = 2'b01, C_REGW = 2'b10, C_REGR = 2'b11} cmd_t;
  typedef enum logic [3:0] {
    IDLE, CMDACK, WR_DATA, WR_STP, RD_TA1, RD_DATA, RD_TA2, TX_DATA, RX_TA1, RX_CMD, RX_TA2
`ifdef ULPI_PHY_EXTREG_EN
    , EXT_ADDR
`endif
  } state_t;

  state_t     state, state_n;
  cmd_t       cmd, cmd_n;
  logic [7:0] addr, addr_n, wdata, wdata_n, rx_hold, rx_hold_n;
  logic [7:0] hold_data, hold_data_n;
  logic       hold_valid, hold_valid_n;
  logic [7:0] regs [REG_COUNT];
  logic       addr_ok, we;
  logic [7:0] rd_val;

  logic       dir_q, nxt_q, oe_q, dir_n, nxt_n, oe_n;
  logic [7:0] dout_q, dout_n, tx_data_n, wa_n, wd_n;
  logic       ready_n, txv_n, txl_n, stb_n;

  assign addr_ok = {1'b0, addr} < REG_LIM;
  assign rd_val  = addr_ok ? regs[addr[AW-1:0]] : 8'h00;

  always_comb begin
    state_n = state; cmd_n = cmd; addr_n = addr; wdata_n = wdata; rx_hold_n = rx_hold;
    hold_data_n = hold_data; hold_valid_n = hold_valid;
    we = 1'b0; stb_n = 1'b0; wa_n = reg_wr_addr; wd_n = reg_wr_data;
    txv_n = 1'b0; txl_n = 1'b0; tx_data_n = tx_data;
    case (state)
      IDLE: begin
        if (bus.ulpi_data_i[7:6] != 2'b00) begin
          cmd_n   = cmd_t'(bus.ulpi_data_i[7:6]);
          addr_n  = {2'b00, bus.ulpi_data_i[5:0]};
          state_n = CMDACK;
        end else if (!bus.ulpi_stp && rxcmd_valid) begin
          rx_hold_n = rxcmd;
          state_n   = RX_TA1;
        end
      end
      CMDACK: begin
        hold_valid_n = 1'b0;
        if (bus.ulpi_stp)         state_n = IDLE;
        else if (cmd == C_TXPKT)  state_n = TX_DATA;
`ifdef ULPI_PHY_EXTREG_EN
        else if (addr == 8'h2F)   state_n = EXT_ADDR;
`endif
        else if (cmd == C_REGW)   state_n = WR_DATA;
        else                      state_n = RD_TA1;
      end
`ifdef ULPI_PHY_EXTREG_EN
      EXT_ADDR: begin
        if (bus.ulpi_stp) state_n = IDLE;
        else begin
          addr_n  = bus.ulpi_data_i;
          state_n = (cmd == C_REGW) ? WR_DATA : RD_TA1;
        end
      end
`endif
      WR_DATA: begin
        if (bus.ulpi_stp) state_n = IDLE;
        else begin
          wdata_n = bus.ulpi_data_i;
          state_n = WR_STP;
        end
      end
      WR_STP: begin
        if (bus.ulpi_stp) begin
          state_n = IDLE;
          if (addr_ok) begin
            we = 1'b1; stb_n = 1'b1; wa_n = addr; wd_n = wdata;
          end
        end
      end
      RD_TA1:  state_n = RD_DATA;
      RD_DATA: state_n = RD_TA2;
      RD_TA2:  state_n = IDLE;
      TX_DATA: begin
        // One-byte holding register lets the final byte be tagged tx_last once stp arrives.
        if (bus.ulpi_stp) begin
          txv_n = hold_valid; txl_n = hold_valid;
          if (hold_valid) tx_data_n = hold_data;
          hold_valid_n = 1'b0;
          state_n = IDLE;
        end else begin
          if (hold_valid) begin
            txv_n = 1'b1; tx_data_n = hold_data;
          end
          hold_data_n  = bus.ulpi_data_i;
          hold_valid_n = 1'b1;
        end
      end
      RX_TA1:  state_n = RX_CMD;
      RX_CMD:  state_n = RX_TA2;
      RX_TA2:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    dir_n = 1'b0; nxt_n = 1'b0; oe_n = 1'b0; dout_n = 8'h00; ready_n = 1'b0;
    case (state_n)
      CMDACK, WR_DATA, TX_DATA: nxt_n = 1'b1;
`ifdef ULPI_PHY_EXTREG_EN
      EXT_ADDR: nxt_n = 1'b1;
`endif
      RD_TA1:  dir_n = 1'b1;
      RD_DATA: begin dir_n = 1'b1; oe_n = 1'b1; dout_n = rd_val; end
      RX_TA1:  begin dir_n = 1'b1; ready_n = 1'b1; end
      RX_CMD:  begin dir_n = 1'b1; oe_n = 1'b1; dout_n = rx_hold; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE; cmd <= C_IDLE; addr <= 8'h00; wdata <= 8'h00; rx_hold <= 8'h00;
      hold_data <= 8'h00; hold_valid <= 1'b0;
      dir_q <= 1'b0; nxt_q <= 1'b0; oe_q <= 1'b0; dout_q <= 8'h00;
      rxcmd_ready <= 1'b0; tx_data <= 8'h00; tx_valid <= 1'b0; tx_last <= 1'b0;
      reg_wr_strobe <= 1'b0; reg_wr_addr <= 8'h00; reg_wr_data <= 8'h00;
      for (int i = 0; i < REG_COUNT; i++)
        regs[i] <= (i == 0) ? VENDOR_ID[7:0] : (i == 1) ? VENDOR_ID[15:8] : 8'h00;
    end else begin
      state <= state_n; cmd <= cmd_n; addr <= addr_n; wdata <= wdata_n; rx_hold <= rx_hold_n;
      hold_data <= hold_data_n; hold_valid <= hold_valid_n;
      dir_q <= dir_n; nxt_q <= nxt_n; oe_q <= oe_n; dout_q <= dout_n;
      rxcmd_ready <= ready_n; tx_data <= tx_data_n; tx_valid <= txv_n; tx_last <= txl_n;
      reg_wr_strobe <= stb_n; reg_wr_addr <= wa_n; reg_wr_data <= wd_n;
      if (we) regs[addr[AW-1:0]] <= wdata;
    end
  end

  assign bus.ulpi_dir     = dir_q;
  assign bus.ulpi_nxt     = nxt_q;
  assign bus.ulpi_data_oe = oe_q;
  assign bus.ulpi_data_o  = dout_q;
endmodule

// File: tb/tb_ulpi_phy_model.sv
// tb/tb_ulpi_phy_model.sv - directed vector bench for ulpi_phy_model
module tb_ulpi_phy_model;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rxcmd;
  logic       rxcmd_valid, rxcmd_ready;
  logic [7:0] tx_data, reg_wr_addr, reg_wr_data;
  logic       tx_valid, tx_last, reg_wr_strobe;

  ulpi_phy_model_if bus ();

  ulpi_phy_model #(.REG_COUNT(16), .VENDOR_ID(16'h0424)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .rxcmd(rxcmd), .rxcmd_valid(rxcmd_valid), .rxcmd_ready(rxcmd_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .reg_wr_strobe(reg_wr_strobe), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] di;
    logic       stp;
    logic       rxv;
    logic [7:0] rxc;
    logic [2:0] dno;   // {dir, nxt, oe}
    logic [7:0] dout;
    logic       rdy;
    logic [1:0] txvl;  // {tx_valid, tx_last}
    logic [7:0] txd;
    logic       stb;
    logic [7:0] wa;
    logic [7:0] wd;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  task automatic add(string name, logic rst, logic [7:0] di, logic stp, logic rxv, logic [7:0] rxc,
                     logic [2:0] dno, logic [7:0] dout, logic rdy, logic [1:0] txvl, logic [7:0] txd,
                     logic stb, logic [7:0] wa, logic [7:0] wd);
    vec_t v;
    v.name = name; v.rst = rst; v.di = di; v.stp = stp; v.rxv = rxv; v.rxc = rxc;
    v.dno = dno; v.dout = dout; v.rdy = rdy; v.txvl = txvl; v.txd = txd;
    v.stb = stb; v.wa = wa; v.wd = wd;
    vecs.push_back(v);
  endtask

  // Data fields are compared only where their qualifier is expected high.
  task automatic check(vec_t e);
    logic [38:0] got, exp;
    got = {bus.ulpi_dir, bus.ulpi_nxt, bus.ulpi_data_oe, e.dno[0] ? bus.ulpi_data_o : 8'h00,
           rxcmd_ready, tx_valid, tx_last, e.txvl[1] ? tx_data : 8'h00,
           reg_wr_strobe, e.stb ? reg_wr_addr : 8'h00, e.stb ? reg_wr_data : 8'h00};
    exp = {e.dno, e.dno[0] ? e.dout : 8'h00, e.rdy, e.txvl, e.txvl[1] ? e.txd : 8'h00,
           e.stb, e.stb ? e.wa : 8'h00, e.stb ? e.wd : 8'h00};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", e.name, got, exp);
    end
  endtask

  task automatic drive(logic rst, logic [7:0] di, logic stp, logic rxv, logic [7:0] rxc);
    reset = rst; bus.ulpi_data_i = di; bus.ulpi_stp = stp; rxcmd_valid = rxv; rxcmd = rxc;
  endtask

  task automatic regr(string n, logic [7:0] c, logic [7:0] d);
    add({n, "_cmd"}, 0, c,     0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add({n, "_ta1"}, 0, c,     0, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0);
    add({n, "_dat"}, 0, 8'h00, 0, 0, 0, 3'b101, d, 0, 0, 0, 0, 0, 0);
    add({n, "_ta2"}, 0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add({n, "_idl"}, 0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t z;
    bit seen;
    z.name = "reset_state"; z.dno = 0; z.dout = 0; z.rdy = 0; z.txvl = 0; z.txd = 0;
    z.stb = 0; z.wa = 0; z.wd = 0;

    // register write then read-back
    add("w_cmd",  0, 8'h8A, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("w_ack",  0, 8'h8A, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("w_dat",  0, 8'h55, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("w_stp",  0, 8'h00, 1, 0, 0, 3'b000, 0, 0, 0, 0, 1, 8'h0A, 8'h55);
    add("w_idl",  0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    regr("r_0a", 8'hCA, 8'h55);
    regr("r_vid_lo", 8'hC0, 8'h24);
    regr("r_vid_hi", 8'hC1, 8'h04);
    regr("r_oob", 8'hFF, 8'h00);
    // out-of-range write, abort in WR_DATA, abort in CMDACK
    add("woob_cmd", 0, 8'hBF, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("woob_ack", 0, 8'hBF, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("woob_dat", 0, 8'h77, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("woob_stp", 0, 8'h00, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("wab_cmd",  0, 8'h8B, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("wab_ack",  0, 8'h8B, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("wab_stp",  0, 8'h99, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("wab_idl",  0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    regr("r_0b", 8'hCB, 8'h00);
    add("cab_cmd",  0, 8'h8C, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("cab_stp",  0, 8'h8C, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("cab_idl",  0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    // transmit packets: three bytes, zero bytes, one byte
    add("tx_cmd",  0, 8'h40, 0, 0, 0, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx_ack",  0, 8'h40, 0, 0, 0, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx_b0",   0, 8'hC3, 0, 0, 0, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx_b1",   0, 8'h01, 0, 0, 0, 3'b010, 0, 0, 2'b10, 8'hC3, 0, 0, 0);
    add("tx_b2",   0, 8'h02, 0, 0, 0, 3'b010, 0, 0, 2'b10, 8'h01, 0, 0, 0);
    add("tx_stp",  0, 8'h00, 1, 0, 0, 3'b000, 0, 0, 2'b11, 8'h02, 0, 0, 0);
    add("tx_idl",  0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx0_cmd", 0, 8'h40, 0, 0, 0, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx0_ack", 0, 8'h40, 0, 0, 0, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx0_stp", 0, 8'h00, 1, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx0_idl", 0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx1_cmd", 0, 8'h40, 0, 0, 0, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx1_ack", 0, 8'h40, 0, 0, 0, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx1_b0",  0, 8'hAA, 0, 0, 0, 3'b010, 0, 0, 2'b00, 0, 0, 0, 0);
    add("tx1_stp", 0, 8'h00, 1, 0, 0, 3'b000, 0, 0, 2'b11, 8'hAA, 0, 0, 0);
    add("tx1_idl", 0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0);
    // RX CMD injection on an idle bus
    add("rx_req",  0, 8'h00, 0, 1, 8'h4C, 3'b100, 0, 1, 0, 0, 0, 0, 0);
    add("rx_cmd",  0, 8'h00, 0, 0, 8'h00, 3'b101, 8'h4C, 0, 0, 0, 0, 0, 0);
    add("rx_ta2",  0, 8'h00, 0, 0, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("rx_idl",  0, 8'h00, 0, 0, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    // link command and RX CMD request in the same IDLE cycle
    add("arb_cmd", 0, 8'h8A, 0, 1, 8'h4C, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("arb_ack", 0, 8'h8A, 0, 1, 8'h4C, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("arb_dat", 0, 8'h66, 0, 1, 8'h4C, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("arb_stp", 0, 8'h00, 1, 1, 8'h4C, 3'b000, 0, 0, 0, 0, 1, 8'h0A, 8'h66);
    add("arb_rx1", 0, 8'h00, 0, 1, 8'h4C, 3'b100, 0, 1, 0, 0, 0, 0, 0);
    add("arb_rx2", 0, 8'h00, 0, 0, 8'h00, 3'b101, 8'h4C, 0, 0, 0, 0, 0, 0);
    add("arb_rx3", 0, 8'h00, 0, 0, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("arb_idl", 0, 8'h00, 0, 0, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    regr("r_0a_arb", 8'hCA, 8'h66);
    // reset during RD_DATA
    add("rrs_cmd", 0, 8'hC0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("rrs_ta1", 0, 8'hC0, 0, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0);
    add("rrs_dat", 0, 8'h00, 0, 0, 0, 3'b101, 8'h24, 0, 0, 0, 0, 0, 0);
    add("rrs_rst", 1, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add("rrs_idl", 0, 8'h00, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    regr("r_after_rst", 8'hC0, 8'h24);
    regr("r_0a_cleared", 8'hCA, 8'h00);
    // reset during a packet with an rxcmd pending: no tx output, no ack
    add("trs_cmd", 0, 8'h40, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("trs_ack", 0, 8'h40, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("trs_b0",  0, 8'hC3, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0);
    add("trs_rst", 1, 8'h01, 0, 1, 8'h4C, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0);
    add("trs_idl", 0, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0);
    add("trs_id2", 0, 8'h00, 0, 0, 8'h00, 3'b000, 0, 0, 2'b00, 0, 0, 0, 0);

    drive(1, 8'h00, 0, 0, 8'h00);
    repeat (3) @(posedge clk);
    #1 check(z);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      z.name = $sformatf("idle_%0d", i);
      check(z);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].di, vecs[i].stp, vecs[i].rxv, vecs[i].rxc);
      @(posedge clk);
      #1 check(vecs[i]);
    end

    // Handshake-driven RX CMD request, bounded waits.
    drive(0, 8'h00, 0, 1, 8'h4E);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(posedge clk);
      #1 seen = rxcmd_ready;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL hs_ready got=0 expected=1 within 8 cycles");
    end
    rxcmd_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({bus.ulpi_dir, bus.ulpi_data_oe, bus.ulpi_data_o, rxcmd_ready} !== {2'b11, 8'h4E, 1'b0}) begin
      bad++;
      $display("FAIL hs_data got=%b/%b/%h/%b expected=1/1/4e/0", bus.ulpi_dir, bus.ulpi_data_oe,
               bus.ulpi_data_o, rxcmd_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if ({bus.ulpi_dir, bus.ulpi_data_oe} !== 2'b00) begin
      bad++;
      $display("FAIL hs_release got=%b%b expected=00", bus.ulpi_dir, bus.ulpi_data_oe);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
